// File: rtl/dcache_wb_param.sv
// Direct-mapped write-back, write-allocate data cache with multi-word lines, burst fill/evict,
// byte-enable stores, whole-cache flush and hit/miss/write-back counters.
module dcache_wb_param #(
  parameter int unsigned LINES          = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned CNT_W          = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      address,
  input  logic [31:0]      value,
  input  logic [3:0]       byteEn,
  input  logic             flush,
  output logic [31:0]      outData,
  output logic             miss,
  output logic             flushDone,
  output logic [31:0]      addressToRAM,
  output logic [31:0]      valueRAM,
  output logic             readRAM,
  output logic             writeRAM,
  input  logic [31:0]      outRAM,
  input  logic             ramReady,
  input  logic             dataUsingRAM,
  output logic [CNT_W-1:0] hitCount,
  output logic [CNT_W-1:0] missCount,
  output logic [CNT_W-1:0] wbCount
);

  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int unsigned BEAT_W  = (OFF_W > 0) ? OFF_W : 1;
  localparam int unsigned TAG_W   = 30 - INDEX_W - OFF_W;

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StWriteBack = 2'd1;
  localparam logic [1:0] StFill      = 2'd2;
  localparam logic [1:0] StFlush     = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [1:0]         ret_q, ret_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [INDEX_W-1:0] flush_idx_q, flush_idx_d;
  logic [INDEX_W-1:0] wb_idx_q, wb_idx_d;
  logic               flush_done_q, flush_done_d;
  logic [LINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [31:0]        data_q [LINES][WORDS_PER_LINE];
  logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q, wb_cnt_q;

  logic [31:0]        word_addr;
  logic [BEAT_W-1:0]  req_off;
  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               req, is_write, hit, beat_ok, last_beat;
  logic               hit_inc, store_en, fill_en, fill_done, wb_done;

  // Word offset is masked rather than sliced so single-word lines need no special case.
  assign word_addr = address >> 2;
  assign req_off   = BEAT_W'(word_addr & 32'(WORDS_PER_LINE - 1));
  assign req_idx   = INDEX_W'(word_addr >> OFF_W);
  assign req_tag   = TAG_W'(word_addr >> (OFF_W + INDEX_W));

  assign req       = read | write;
  assign is_write  = write & ~read;
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign beat_ok   = dataUsingRAM & ramReady;
  assign last_beat = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0]   t,
                                            input logic [INDEX_W-1:0] i,
                                            input logic [BEAT_W-1:0]  b);
    logic [31:0] w;
    w = (32'(t) << (INDEX_W + OFF_W)) | (32'(i) << OFF_W) | (32'(b) & 32'(WORDS_PER_LINE - 1));
    return w << 2;
  endfunction

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    beat_d       = beat_q;
    flush_idx_d  = flush_idx_q;
    wb_idx_d     = wb_idx_q;
    flush_done_d = 1'b0;
    hit_inc      = 1'b0;
    store_en     = 1'b0;
    fill_en      = 1'b0;
    fill_done    = 1'b0;
    wb_done      = 1'b0;
    miss         = 1'b0;
    readRAM      = 1'b0;
    writeRAM     = 1'b0;
    valueRAM     = '0;
    addressToRAM = address;
    outData      = data_q[req_idx][req_off];

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            hit_inc  = 1'b1;
            store_en = is_write;
          end else begin
            miss   = 1'b1;
            beat_d = '0;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_d  = StWriteBack;
              ret_d    = StFill;
              wb_idx_d = req_idx;
            end else begin
              state_d = StFill;
            end
          end
        end else if (flush) begin
          miss        = 1'b1;
          state_d     = StFlush;
          flush_idx_d = '0;
        end
      end
      StWriteBack: begin
        miss         = req | (ret_q == StFlush);
        writeRAM     = 1'b1;
        addressToRAM = line_addr(tag_q[wb_idx_q], wb_idx_q, beat_q);
        valueRAM     = data_q[wb_idx_q][beat_q];
        if (beat_ok) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            wb_done = 1'b1;
            beat_d  = '0;
            // Last line of a flush scan finishes straight from the write-back.
            if (ret_q == StFlush && wb_idx_q == INDEX_W'(LINES - 1)) begin
              state_d      = StIdle;
              flush_done_d = 1'b1;
            end else begin
              state_d = ret_q;
            end
          end
        end
      end
      StFill: begin
        miss         = req;
        readRAM      = 1'b1;
        addressToRAM = line_addr(req_tag, req_idx, beat_q);
        if (beat_ok) begin
          fill_en = 1'b1;
          beat_d  = beat_q + BEAT_W'(1);
          if (last_beat) begin
            fill_done = 1'b1;
            beat_d    = '0;
            state_d   = StIdle;
          end
        end
      end
      StFlush: begin
        miss = 1'b1;
        if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
          state_d     = StWriteBack;
          ret_d       = StFlush;
          wb_idx_d    = flush_idx_q;
          beat_d      = '0;
          flush_idx_d = flush_idx_q + INDEX_W'(1);
        end else if (flush_idx_q == INDEX_W'(LINES - 1)) begin
          state_d      = StIdle;
          flush_done_d = 1'b1;
        end else begin
          flush_idx_d = flush_idx_q + INDEX_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      ret_q        <= StIdle;
      beat_q       <= '0;
      flush_idx_q  <= '0;
      wb_idx_q     <= '0;
      flush_done_q <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      wb_cnt_q     <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= '0;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
          data_q[i][w] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      beat_q       <= beat_d;
      flush_idx_q  <= flush_idx_d;
      wb_idx_q     <= wb_idx_d;
      flush_done_q <= flush_done_d;
      if (store_en) begin
        for (int b = 0; b < 4; b++) begin
          if (byteEn[b]) data_q[req_idx][req_off][8*b +: 8] <= value[8*b +: 8];
        end
        dirty_q[req_idx] <= 1'b1;
      end
      if (fill_en) data_q[req_idx][beat_q] <= outRAM;
      if (fill_done) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
        tag_q[req_idx]   <= req_tag;
      end
      if (wb_done) dirty_q[wb_idx_q] <= 1'b0;
      if (hit_inc)   hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
      if (fill_done) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      if (wb_done)   wb_cnt_q   <= wb_cnt_q + CNT_W'(1);
    end
  end

  assign flushDone = flush_done_q;
  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
  assign wbCount   = wb_cnt_q;

endmodule

// File: tb/tb_dcache_wb_param.sv
// Bench for dcache_wb_param: table of accesses against an architectural memory model, with a
// RAM-beat scoreboard plus hand-written flush and reset-mid-fill sequences.
module tb_dcache_wb_param;

  localparam int WPL   = 4;
  localparam int NLINE = 32;

  logic        clock = 1'b0;
  logic        reset, read, write, flush;
  logic [31:0] address, value;
  logic [3:0]  byteEn;
  logic [31:0] outData, addressToRAM, valueRAM, outRAM;
  logic        miss, flushDone, readRAM, writeRAM, ramReady, dataUsingRAM;
  logic [63:0] hitCount, missCount, wbCount;

  dcache_wb_param dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .write        (write),
    .address      (address),
    .value        (value),
    .byteEn       (byteEn),
    .flush        (flush),
    .outData      (outData),
    .miss         (miss),
    .flushDone    (flushDone),
    .addressToRAM (addressToRAM),
    .valueRAM     (valueRAM),
    .readRAM      (readRAM),
    .writeRAM     (writeRAM),
    .outRAM       (outRAM),
    .ramReady     (ramReady),
    .dataUsingRAM (dataUsingRAM),
    .hitCount     (hitCount),
    .missCount    (missCount),
    .wbCount      (wbCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] val;
    logic [3:0]  be;
    int          miss_cyc;
    bit          has_wb;
    logic [31:0] wb_base;
    bit          has_fill;
    logic [31:0] stall_addr;
    int          stall_len;
    bit          stall_gnt;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  int          n_vec = 0;
  int          n_err = 0;
  longint      exp_hit = 0, exp_miss = 0, exp_wb = 0;
  beat_t       exp_q[$];
  logic [31:0] model [logic [31:0]];
  vec_t        vecs [18];

  // RAM returns each word's own address, except one preset word.
  function automatic logic [31:0] ram_init(input logic [31:0] a);
    return (a == 32'h14) ? 32'h1122_3344 : a;
  endfunction

  function automatic logic [31:0] arch(input logic [31:0] a);
    if (model.exists(a)) return model[a];
    return ram_init(a);
  endfunction

  assign outRAM = ram_init(addressToRAM);

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] val, input logic [3:0] be, input int mc,
                              input bit has_wb, input logic [31:0] wb_base, input bit has_fill,
                              input logic [31:0] st_addr, input int st_len, input bit st_gnt);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.val = val; v.be = be; v.miss_cyc = mc;
    v.has_wb = has_wb; v.wb_base = wb_base; v.has_fill = has_fill;
    v.stall_addr = st_addr; v.stall_len = st_len; v.stall_gnt = st_gnt;
    return v;
  endfunction

  // Every accepted RAM beat must match the next expected beat.
  always @(negedge clock) begin
    if ((readRAM || writeRAM) && dataUsingRAM && ramReady) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {32'b0, addressToRAM}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_kind", {62'b0, writeRAM, readRAM}, {62'b0, b.wr, ~b.wr});
        check("beat_addr", {32'b0, addressToRAM}, {32'b0, b.addr});
        if (b.wr) check("beat_data", {32'b0, valueRAM}, {32'b0, b.data});
      end
    end
  end

  task automatic run_vec(input vec_t v, input string nm);
    int          cyc, left;
    bit          done, started;
    logic [1:0]  strobes;
    logic [31:0] wa, word;
    wa = v.addr & 32'hFFFF_FFFC;
    if (v.has_wb)
      for (int k = 0; k < WPL; k++) exp_q.push_back('{1'b1, v.wb_base + 32'(4*k), arch(v.wb_base + 32'(4*k))});
    if (v.has_fill)
      for (int k = 0; k < WPL; k++) exp_q.push_back('{1'b0, (v.addr & 32'hFFFF_FFF0) + 32'(4*k), 32'h0});
    read = v.rd; write = v.wr; address = v.addr; value = v.val; byteEn = v.be;
    cyc = 0; done = 0; left = v.stall_len; started = 0; strobes = 2'b00;
    while (!done) begin
      ramReady = 1'b1; dataUsingRAM = 1'b1;
      if (started && left > 0) begin
        check({nm, "_stall_addr"}, {32'b0, addressToRAM}, {32'b0, v.stall_addr});
        check({nm, "_stall_strobe"}, {62'b0, readRAM, writeRAM}, {62'b0, strobes});
      end else if (!started && left > 0 && (readRAM || writeRAM) && addressToRAM == v.stall_addr) begin
        started = 1; strobes = {readRAM, writeRAM};
      end
      if (started && left > 0) begin
        if (v.stall_gnt) dataUsingRAM = 1'b0; else ramReady = 1'b0;
        left--;
      end
      @(negedge clock);
      if (!miss) done = 1;
      else begin
        cyc++;
        if (cyc >= 100) begin
          n_vec++; n_err++;
          $display("FAIL %s_timeout: miss still high after %0d cycles", nm, cyc);
          done = 1;
        end
        @(posedge clock); #1;
      end
    end
    if (v.rd) check({nm, "_out"}, {32'b0, outData}, {32'b0, arch(wa)});
    check({nm, "_miss_cycles"}, 64'(cyc), 64'(v.miss_cyc));
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
    ramReady = 1'b1; dataUsingRAM = 1'b1;
    if (v.wr && !v.rd) begin
      word = arch(wa);
      for (int b = 0; b < 4; b++) if (v.be[b]) word[8*b +: 8] = v.val[8*b +: 8];
      model[wa] = word;
    end
    exp_hit++;
    if (v.has_fill) exp_miss++;
    if (v.has_wb) exp_wb++;
  endtask

  task automatic check_counters(input string nm);
    check({nm, "_hitCount"},  hitCount,  64'(exp_hit));
    check({nm, "_missCount"}, missCount, 64'(exp_miss));
    check({nm, "_wbCount"},   wbCount,   64'(exp_wb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first_n, pulses;
    bit hit_b1;
    //            rd wr addr           val            be     mc wb base   fl stall        len gnt
    vecs[0]  = mk(1, 0, 32'h0000_0010, 32'h0,         4'h0,  5, 0, 32'h0,  1, 32'h0,      0, 0);
    vecs[1]  = mk(1, 0, 32'h0000_0014, 32'h0,         4'h0,  0, 0, 32'h0,  0, 32'h0,      0, 0);
    vecs[2]  = mk(0, 1, 32'h0000_0014, 32'hAABB_CCDD, 4'h3,  0, 0, 32'h0,  0, 32'h0,      0, 0);
    vecs[3]  = mk(1, 0, 32'h0000_0014, 32'h0,         4'h0,  0, 0, 32'h0,  0, 32'h0,      0, 0);
    vecs[4]  = mk(1, 0, 32'h0000_0210, 32'h0,         4'h0,  9, 1, 32'h10, 1, 32'h0,      0, 0);
    vecs[5]  = mk(0, 1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF,  5, 0, 32'h0,  1, 32'h0,      0, 0);
    vecs[6]  = mk(0, 1, 32'h0000_0050, 32'h1234_5678, 4'h8,  5, 0, 32'h0,  1, 32'h0,      0, 0);
    vecs[7]  = mk(1, 0, 32'h0000_0058, 32'h0,         4'h0,  0, 0, 32'h0,  0, 32'h0,      0, 0);
    vecs[8]  = mk(1, 1, 32'h0000_021C, 32'hFFFF_FFFF, 4'hF,  0, 0, 32'h0,  0, 32'h0,      0, 0);
    vecs[9]  = mk(1, 0, 32'h0000_021C, 32'h0,         4'h0,  0, 0, 32'h0,  0, 32'h0,      0, 0);
    vecs[10] = mk(1, 0, 32'h0000_0410, 32'h0,         4'h0,  8, 0, 32'h0,  1, 32'h418,    3, 0);
    vecs[11] = mk(1, 0, 32'h0000_0000, 32'h0,         4'h0,  0, 0, 32'h0,  0, 32'h0,      0, 0);
    vecs[12] = mk(1, 0, 32'h0000_0050, 32'h0,         4'h0,  0, 0, 32'h0,  0, 32'h0,      0, 0);
    vecs[13] = mk(1, 0, 32'h0000_0200, 32'h0,         4'h0,  5, 0, 32'h0,  1, 32'h0,      0, 0);
    vecs[14] = mk(0, 1, 32'h0000_0034, 32'hFFFF_FFFF, 4'h0,  5, 0, 32'h0,  1, 32'h0,      0, 0);
    vecs[15] = mk(1, 0, 32'h0000_0234, 32'h0,         4'h0, 11, 1, 32'h30, 1, 32'h34,     2, 1);
    vecs[16] = mk(0, 1, 32'h0000_0238, 32'h0BAD_F00D, 4'hF,  0, 0, 32'h0,  0, 32'h0,      0, 0);
    vecs[17] = mk(1, 0, 32'h0000_0238, 32'h0,         4'h0,  0, 0, 32'h0,  0, 32'h0,      0, 0);

    reset = 1'b1; read = 1'b0; write = 1'b0; flush = 1'b0;
    address = 32'h1234_5678; value = '0; byteEn = '0;
    ramReady = 1'b1; dataUsingRAM = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_readRAM",   {63'b0, readRAM},   64'h0);
    check("rst_writeRAM",  {63'b0, writeRAM},  64'h0);
    check("rst_flushDone", {63'b0, flushDone}, 64'h0);
    check("rst_miss",      {63'b0, miss},      64'h0);
    check("rst_valueRAM",  {32'b0, valueRAM},  64'h0);
    check("rst_addr_pass", {32'b0, addressToRAM}, 64'h1234_5678);
    check_counters("rst");
    @(posedge clock); #1;

    for (int i = 0; i <= 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    check_counters("pre_flush");

    // Flush with lines 0 and 5 dirty.
    for (int k = 0; k < WPL; k++) exp_q.push_back('{1'b1, 32'(4*k), arch(32'(4*k))});
    for (int k = 0; k < WPL; k++) exp_q.push_back('{1'b1, 32'h50 + 32'(4*k), arch(32'h50 + 32'(4*k))});
    flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    first_n = 0; pulses = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (flushDone) begin
        pulses++;
        if (first_n == 0) first_n = n;
      end
    end
    check("flush_done_cycle",  64'(first_n), 64'(NLINE + 2*WPL + 1));
    check("flush_done_pulses", 64'(pulses), 64'd1);
    exp_wb += 2;
    @(posedge clock); #1;

    for (int i = 11; i <= 17; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    check_counters("post_flush");

    // Reset during beat 1 of a fill abandons the burst.
    exp_q.push_back('{1'b0, 32'h610, 32'h0});
    exp_q.push_back('{1'b0, 32'h614, 32'h0});
    read = 1'b1; address = 32'h610;
    hit_b1 = 0;
    for (int n = 0; n < 20 && !hit_b1; n++) begin
      @(negedge clock);
      if (readRAM && addressToRAM == 32'h614) hit_b1 = 1;
    end
    check("rst_fill_reached_beat1", {63'b0, hit_b1}, 64'h1);
    #1 reset = 1'b1; read = 1'b0;
    @(posedge clock); #1;
    check("rst_fill_readRAM", {63'b0, readRAM}, 64'h0);
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    check_counters("rst_fill");
    reset = 1'b0;
    model.delete();
    run_vec(mk(1, 0, 32'h610, 32'h0, 4'h0, 5, 0, 32'h0, 1, 32'h0, 0, 0), "refill");
    run_vec(mk(1, 0, 32'h014, 32'h0, 4'h0, 5, 0, 32'h0, 1, 32'h0, 0, 0), "cleared_line");
    check_counters("final");
    check("beats_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_wb_param.md
# dcache_wb_param

Parametrised direct-mapped, write-back, write-allocate data cache that sits between the pipeline's MEM stage and the shared RAM arbiter. Successor of the fixed 128-byte, one-word-per-line data cache. Adds:
- configurable line count and multi-word lines, filled and evicted as word bursts;
- byte-enable writes;
- a whole-cache flush command;
- exported hit/miss/write-back performance counters.

## Interface
Parameters:
- LINES, 32, number of lines; power of two, ≥2; INDEX_W = log2(LINES)
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, ≥1; OFF_W = log2(WORDS_PER_LINE)
- CNT_W, 64, width of each performance counter
- Derived: TAG_W = 30 − INDEX_W − OFF_W; address = {tag, index, word offset, 2'b00}; address[1:0] ignored

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- read  in  1  load request, held by the pipeline until miss is low
- write  in  1  store request, held by the pipeline until miss is low
- address  in  32  byte address of the access
- value  in  32  store data
- byteEn  in  4  store byte lanes; byteEn[3] selects bits 31:24
- flush  in  1  single-cycle flush command
- outData  out  32  load data; combinational
- miss  out  1  stall: (read|write|flush activity) && access not completing this cycle
- flushDone  out  1  one-cycle pulse when a flush completes
- addressToRAM  out  32  RAM beat address
- valueRAM  out  32  RAM write-beat data
- readRAM  out  1  fill burst active
- writeRAM  out  1  write-back burst active
- outRAM  in  32  RAM read data
- ramReady  in  1  RAM beat complete
- dataUsingRAM  in  1  arbiter grant to this cache
- hitCount, missCount, wbCount  out  CNT_W each  performance counters

## Operation
- Storage: per line valid, dirty, tag, WORDS_PER_LINE×32 data. All storage is cleared on reset, so dirty contents are discarded.
- States: IDLE, WRITE_BACK, FILL, FLUSH.
- IDLE hit (valid[idx] && tag match):
  - read: outData = line word[offset], miss = 0.
  - write: merge value into the selected word by byteEn at the clock edge; set dirty. Example: byteEn=0000 still sets dirty.
- IDLE miss, victim dirty: go to WRITE_BACK with return target FILL.
- IDLE miss, victim clean: go to FILL.
- Read priority: if read and write are both high, the access is a read and write is ignored.
- WRITE_BACK:
  - writeRAM = 1; addressToRAM = {victim tag, idx, beat, 00}; valueRAM = word[beat].
  - A beat is accepted in a cycle with dataUsingRAM && ramReady; beat then increments.
  - On the last accepted beat: clear dirty, wbCount++, writeRAM = 0 next cycle, go to the return target.
- FILL:
  - readRAM = 1; addressToRAM = {req tag, idx, beat, 00}.
  - On each accepted beat, outRAM is written into word[beat].
  - On the last beat: valid = 1, tag = req tag, dirty = 0, missCount++, readRAM = 0, go to IDLE.
  - The held request then hits. A store completes through the hit path (write-allocate).
- FLUSH:
  - Accepted only in IDLE with read = write = 0; otherwise ignored.
  - Scans i = 0..LINES−1, one line per cycle.
  - For a valid && dirty line: WRITE_BACK line i, return target FLUSH at i+1. Lines stay valid.
  - After line LINES−1: flushDone = 1 for one cycle, then IDLE.
  - Any read/write presented during FLUSH sees miss = 1.
- hitCount increments once per completed access (read|write && !miss); repeated stall cycles do not count.
- Counters wrap modulo 2^CNT_W.
- Outside bursts: addressToRAM = request address, RAM strobes low.

## Timing
- Reset values: state IDLE, all strobes 0, flushDone 0, counters 0, valid/dirty 0, beat 0, valueRAM 0.
- Hit: zero added latency; combinational miss = 0 in the request cycle.
- Clean miss: miss high for 1 + WORDS_PER_LINE cycles minimum (decision cycle + one beat per cycle with grant and ramReady constant high).
- Dirty miss: 1 + 2·WORDS_PER_LINE cycles minimum.
- RAM stalls:
  - dataUsingRAM or ramReady low: beat and address hold, strobe stays high, no data change.
  - Grant may drop mid-burst; the burst resumes at the same beat.
- Flush: LINES + (dirty lines × WORDS_PER_LINE) cycles minimum, plus the flushDone cycle.
- Reset asserted in any state: the next cycle is the reset state; the burst is abandoned and strobes drop.

## Test plan
- Cold read, defaults, RAM returns word = its address, always ready:
  - read 0x0000_0010 → miss high 5 cycles; readRAM beats at 0x10, 0x14, 0x18, 0x1C.
  - Then outData = 0x0000_0010, missCount = 1, hitCount = 1.
- Byte-enable store hit:
  - Line holds 0x11223344 at 0x14; write 0xAABBCCDD, byteEn = 0011 → miss = 0.
  - Subsequent read 0x14 returns 0x1122CCDD; dirty set.
- Conflict eviction:
  - After the store, read 0x0000_0210 (same index, new tag).
  - → writeRAM beats 0x10..0x1C with the line data; then readRAM beats 0x210..0x21C; wbCount = 1, missCount = 2.
- Stalled fill:
  - ramReady low 3 cycles at beat 2 → addressToRAM holds 0x18, readRAM stays 1.
  - Miss lasts 8 cycles; fill data correct.
- Flush, lines 0 and 5 dirty:
  - flush pulse → 8 write beats; flushDone pulses once after 32 + 8 cycles.
  - Dirty bits cleared; reads of those lines then hit with miss = 0.
- Reset mid-fill:
  - Assert reset at beat 1 → readRAM = 0 the next cycle; counters 0.
  - Re-read of the same address misses and refills fully.
